// File: rtl/switch_debouncer_pkg.sv
// Shared constants for the slide-switch debouncer: switch width and default timing.
package switch_debouncer_pkg;

  localparam int unsigned SW_WIDTH        = 8;
  localparam int unsigned DEF_CLK_DIV     = 100000;
  localparam int unsigned DEF_DEBOUNCE_MS = 10;

  typedef logic [SW_WIDTH-1:0] sw_vec_t;

endpackage : switch_debouncer_pkg

// File: rtl/switch_debouncer_debounce_bit.sv
// One switch bit: two-flop synchronizer, tick-based stability counter,
// accepted level and registered edge pulses.
module debounce_bit
  import switch_debouncer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_MS = DEF_DEBOUNCE_MS
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic tick_i,
  input  logic sw_i,
  output logic db_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned   CW   = $clog2(DEBOUNCE_MS + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_MS - 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          db_q, db_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;

  // Counter only advances on ticks while the input disagrees; any agreement
  // restarts the count, so a glitch forfeits all accumulated progress.
  always_comb begin
    cnt_d  = cnt_q;
    db_d   = db_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (sync_q[1] == db_q) begin
      cnt_d = '0;
    end else if (tick_i) begin
      if (cnt_q == LAST) begin
        db_d   = sync_q[1];
        cnt_d  = '0;
        rise_d = sync_q[1];
        fall_d = ~sync_q[1];
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      cnt_q  <= '0;
      db_q   <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], sw_i};
      cnt_q  <= cnt_d;
      db_q   <= db_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign db_o   = db_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule : debounce_bit

// File: rtl/switch_debouncer.sv
// Eight-switch debouncer: one shared tick prescaler feeding a debounce_bit per switch.
module switch_debouncer
  import switch_debouncer_pkg::*;
#(
  parameter int unsigned CLK_DIV     = DEF_CLK_DIV,
  parameter int unsigned DEBOUNCE_MS = DEF_DEBOUNCE_MS
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic [SW_WIDTH-1:0] SW,
  output logic [SW_WIDTH-1:0] SW_DB,
  output logic [SW_WIDTH-1:0] SW_RISE,
  output logic [SW_WIDTH-1:0] SW_FALL,
  output logic                TICK_1K
);

  localparam int unsigned   DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_q, div_d;
  logic          tick;

  // Tick is decoded from the count itself, so it is low out of reset.
  always_comb begin
    tick  = (div_q == DIV_LAST);
    div_d = tick ? '0 : div_q + DW'(1);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  assign TICK_1K = tick;

  for (genvar g = 0; g < SW_WIDTH; g++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_MS (DEBOUNCE_MS)
    ) u_bit (
      .clk_i  (CLK),
      .rst_ni (RST_N),
      .tick_i (tick),
      .sw_i   (SW[g]),
      .db_o   (SW_DB[g]),
      .rise_o (SW_RISE[g]),
      .fall_o (SW_FALL[g])
    );
  end

endmodule : switch_debouncer
